serial_adder_ctrl: RTL

Bit-serial adder controller. It accepts two WIDTH-bit operands and a carry-in, then sequences a single 1-bit full_adder cell LSB-first over WIDTH cycles, holding the running carry in a flop. It presents the WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits in the combinational-circuits lab area as the sequential, area-minimal alternative to a ripple-carry adder built from WIDTH full_adder instances.

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/full_adder.sv | 14 +
 rtl/serial_adder_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants for the bit-serial adder.
// Imported by serial_adder_ctrl.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sa_state_t;

  localparam int SA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// full_adder: 1-bit full adder cell.
// Sequenced over WIDTH bits by serial_adder_ctrl.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: LSB-first bit-serial adder around one full_adder.
// Optional signed-overflow output: define SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sa_state_t state_q, state_d;

  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             accept;
  logic             last;
  logic             fa_s, fa_co;
  logic [WIDTH-1:0] res_next;

  full_adder u_fa (
    .A    (a_sr[0]),
    .B    (b_sr[0]),
    .Cin  (carry),
    .Sum  (fa_s),
    .Cout (fa_co)
  );

  assign res_next = {fa_s, res[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    accept  = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        ready   = 1'b1;
        done    = 1'b1;
        accept  = start;
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // res is the shadow; sum/cout only see it on the final bit step
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= cin;
      cnt   <= '0;
      res   <= '0;
    end else if (busy) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      carry <= fa_co;
      res   <= res_next;
      if (!last) cnt <= cnt + 1'b1;
      if (last) begin
        sum  <= res_next;
        cout <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
        ovf  <= carry ^ fa_co;
`endif
      end
    end
  end

endmodule
